// File: rtl/gpu_pkg.sv
// Shared command-path definitions: word geometry and the opcode fetch FSM states.
package gpu_pkg;
    localparam int WORD_W = 32;
    localparam int WORDS  = 3;

    typedef enum logic {
        LOAD = 1'b0,
        HOLD = 1'b1
    } fetch_state_t;
endpackage

// File: rtl/opcode_fetch_ctrl.sv
// Sequences command words into the external opcode shift register and hands
// complete opcodes to the decoder over an opcode_valid/opcode_ack handshake.
module opcode_fetch_ctrl #(
    parameter int WORD_W = gpu_pkg::WORD_W,
    parameter int WORDS  = gpu_pkg::WORDS,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              word_valid,
    input  logic [WORD_W-1:0] word_in,
    output logic              word_ready,
    output logic              shift_enable,
    output logic [WORD_W-1:0] serial_out,
    output logic              opcode_valid,
    input  logic              opcode_ack,
    input  logic              flush,
    output logic [1:0]        word_cnt,
    output logic [CNT_W-1:0]  opcode_count
);
    import gpu_pkg::*;

    localparam logic [1:0] LAST = 2'(WORDS - 1);

    fetch_state_t state, state_nxt;
    logic [1:0]   cnt_nxt;
    logic         accept;
    logic         deliver;

    // In HOLD the shift register may only move when the decoder is taking the
    // current opcode, which keeps the parallel data stable until the ack.
    assign word_ready   = !flush && (state == LOAD || opcode_ack);
    assign accept       = word_valid && word_ready;
    assign shift_enable = accept;
    assign serial_out   = word_in;
    assign opcode_valid = (state == HOLD);
    assign deliver      = (state == HOLD) && opcode_ack && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= LOAD;
            word_cnt <= '0;
        end else begin
            state    <= state_nxt;
            word_cnt <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = word_cnt;
        if (flush) begin
            state_nxt = LOAD;
            cnt_nxt   = '0;
        end else begin
            unique case (state)
                LOAD: begin
                    if (accept) begin
                        if (word_cnt == LAST) begin
                            state_nxt = HOLD;
                            cnt_nxt   = '0;
                        end else begin
                            cnt_nxt = word_cnt + 2'd1;
                        end
                    end
                end
                HOLD: begin
                    if (opcode_ack) begin
                        state_nxt = LOAD;
                        cnt_nxt   = accept ? 2'd1 : 2'd0;
                    end
                end
                default: begin
                    state_nxt = LOAD;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            opcode_count <= '0;
        else if (deliver)
            opcode_count <= opcode_count + 1'b1;
    end
endmodule

// File: tb/tb_opcode_fetch_ctrl.sv
// Randomized and directed bench for opcode_fetch_ctrl with a queue-based
// reference model and a scoreboard checking the assembled opcode data.
module tb_opcode_fetch_ctrl;
    localparam int WORD_W = 32;
    localparam int WORDS  = 3;
    localparam int CNT_W  = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              word_valid = 1'b0;
    logic [WORD_W-1:0] word_in = '0;
    logic              word_ready;
    logic              shift_enable;
    logic [WORD_W-1:0] serial_out;
    logic              opcode_valid;
    logic              opcode_ack = 1'b0;
    logic              flush = 1'b0;
    logic [1:0]        word_cnt;
    logic [CNT_W-1:0]  opcode_count;

    int compared = 0;
    int mismatched = 0;

    opcode_fetch_ctrl #(.WORD_W(WORD_W), .WORDS(WORDS), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .word_valid(word_valid), .word_in(word_in),
        .word_ready(word_ready), .shift_enable(shift_enable), .serial_out(serial_out),
        .opcode_valid(opcode_valid), .opcode_ack(opcode_ack), .flush(flush),
        .word_cnt(word_cnt), .opcode_count(opcode_count)
    );

    always #5 clk = ~clk;

    // The shift register that sits beside the controller one level up.
    logic [WORDS*WORD_W-1:0] sreg;
    always @(posedge clk or posedge rst) begin
        if (rst) sreg <= '0;
        else if (shift_enable) sreg <= {sreg[(WORDS-1)*WORD_W-1:0], serial_out};
    end

    // Reference model: words of the opcode being assembled, whether a complete
    // opcode is waiting for the decoder, and the delivered count.
    logic [WORD_W-1:0]       part[$];
    logic [WORDS*WORD_W-1:0] exp_q[$];
    bit                      hold_m = 1'b0;
    logic [CNT_W-1:0]        cnt_m = '0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic cyc(input bit v, input logic [WORD_W-1:0] w, input bit a, input bit f);
        bit rdy, acc;
        @(posedge clk);
        #1;
        word_valid = v; word_in = w; opcode_ack = a; flush = f;
        #1;
        rdy = !f && (!hold_m || a);
        acc = v && rdy;
        check("word_ready",   96'(word_ready),   96'(rdy));
        check("shift_enable", 96'(shift_enable), 96'(acc));
        check("serial_out",   96'(serial_out),   96'(w));
        check("opcode_valid", 96'(opcode_valid), 96'(hold_m));
        check("word_cnt",     96'(word_cnt),     96'(part.size()));
        check("opcode_count", 96'(opcode_count), 96'(cnt_m));
        if (f) begin
            part.delete();
            if (hold_m) void'(exp_q.pop_front());
            hold_m = 1'b0;
        end else begin
            if (hold_m && a) begin
                cnt_m++;
                hold_m = 1'b0;
            end
            if (acc) begin
                part.push_back(w);
                if (part.size() == WORDS) begin
                    exp_q.push_back({part[0], part[1], part[2]});
                    part.delete();
                    hold_m = 1'b1;
                end
            end
        end
    endtask

    // Monitor: whenever an opcode is presented, the shift register must hold the
    // oldest expected opcode; an ack retires it.
    always @(negedge clk) begin
        if (!rst && opcode_valid && !flush) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL opcode_data: opcode_valid with no expected opcode at %0t", $time);
            end else begin
                check("opcode_data", sreg, exp_q[0]);
                if (opcode_ack) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        bit to;
        repeat (2) @(posedge clk);
        #2;
        check("rst_opcode_valid", 96'(opcode_valid), 96'(0));
        check("rst_word_cnt",     96'(word_cnt),     96'(0));
        check("rst_opcode_count", 96'(opcode_count), 96'(0));
        check("rst_word_ready",   96'(word_ready),   96'(1));
        @(negedge clk);
        rst = 1'b0;

        // Three words, then a held opcode under word pressure, then ack with 0xD.
        cyc(1, 32'hA, 0, 0); cyc(1, 32'hB, 0, 0); cyc(1, 32'hC, 0, 0);
        repeat (5) cyc(1, 32'hEE, 0, 0);
        cyc(1, 32'hD, 1, 0);
        cyc(0, 32'h0, 0, 0);
        check("ack_count", 96'(opcode_count), 96'(1));
        check("ack_cnt1",  96'(word_cnt),     96'(1));

        // Flush a partial, then reload 1,2,3.
        cyc(1, 32'h5, 0, 0);
        cyc(0, 32'h0, 0, 1);
        cyc(1, 32'h1, 0, 0); cyc(1, 32'h2, 0, 0); cyc(1, 32'h3, 0, 0);
        cyc(0, 32'h0, 0, 0);
        // Flush and ack together while holding: nothing is delivered.
        cyc(0, 32'h0, 1, 1);
        cyc(0, 32'h0, 0, 0);

        // Four back-to-back opcodes with same-cycle ack.
        for (int i = 0; i < 4 * WORDS; i++) cyc(1, 32'h100 + i, 1, 0);
        cyc(0, 32'h0, 1, 0);

        // Counter wrap: preload all-ones, then deliver one more opcode.
        @(posedge clk);
        #3;
        force dut.opcode_count = 16'hFFFF;
        #1;
        release dut.opcode_count;
        cnt_m = 16'hFFFF;
        cyc(1, 32'h7, 0, 0); cyc(1, 32'h8, 0, 0); cyc(1, 32'h9, 0, 0);
        cyc(0, 32'h0, 1, 0);
        cyc(0, 32'h0, 0, 0);
        check("wrap_count", 96'(opcode_count), 96'(0));

        // Randomized traffic.
        for (int i = 0; i < 3000; i++)
            cyc(($urandom % 4) != 0, $urandom, ($urandom % 3) == 0, ($urandom % 16) == 0);

        // Asynchronous reset mid-opcode.
        cyc(1, 32'h21, 0, 0); cyc(1, 32'h22, 0, 0);
        @(posedge clk);
        #1;
        word_valid = 1'b0; opcode_ack = 1'b0; flush = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("arst_word_cnt",     96'(word_cnt),     96'(0));
        check("arst_opcode_valid", 96'(opcode_valid), 96'(0));
        check("arst_opcode_count", 96'(opcode_count), 96'(0));
        check("arst_word_ready",   96'(word_ready),   96'(1));
        check("arst_shift_enable", 96'(shift_enable), 96'(0));
        part.delete(); exp_q.delete(); hold_m = 1'b0; cnt_m = '0;
        @(negedge clk);
        rst = 1'b0;
        cyc(1, 32'h31, 0, 0); cyc(1, 32'h32, 0, 0); cyc(1, 32'h33, 0, 0);
        to = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (opcode_valid) begin to = 1'b0; break; end
            cyc(0, 32'h0, 0, 0);
        end
        check("final_opcode_timeout", 96'(to), 96'(0));
        cyc(0, 32'h0, 1, 0);
        cyc(0, 32'h0, 0, 0);
        check("final_count", 96'(opcode_count), 96'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
